ew_light_sequencer: RTL and testbench



---
 rtl/ew_light_sequencer.sv | 149 ++++++++++++++
 tb/tb_ew_light_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ew_light_sequencer.sv
// rtl/ew_light_sequencer.sv - east-west counter consumer and intersection light sequencer
// Optional macro EW_FAULT_FLASH_EN: flash both yellows while in FAULT instead of steady all-red.
module ew_light_sequencer #(
  parameter int GREEN_TICKS  = 6,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] count,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic [2:0] phase,
  output logic       tick,
  output logic       fault
);

  typedef enum logic [2:0] {
    EW_GREEN  = 3'd0,
    EW_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    NS_GREEN  = 3'd3,
    NS_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    ILLEGAL6  = 3'd6,
    FAULT     = 3'd7
  } state_t;

  localparam logic [3:0] LEN_G = 4'(GREEN_TICKS);
  localparam logic [3:0] LEN_Y = 4'(YELLOW_TICKS);
  localparam logic [3:0] LEN_R = 4'(ALLRED_TICKS);

  logic [3:0] cnt_q;
  logic [3:0] prev_q;
  logic [1:0] arm_sr;
  logic       armed;
  logic       fault_q;
  logic       step_err;
  logic [3:0] dwell;
  logic [3:0] len;
  state_t     state;
  state_t     nxt;

  assign armed    = arm_sr[1];
  assign tick     = armed && (prev_q == 4'hF) && (cnt_q == 4'h0);
  assign step_err = armed && (cnt_q != prev_q + 4'd1);
  assign fault    = fault_q;
  assign phase    = state;

  // Sample the counter twice so both cnt_q and prev_q hold real values before checks arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      prev_q  <= 4'd0;
      arm_sr  <= 2'b00;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= count;
      prev_q  <= cnt_q;
      arm_sr  <= {arm_sr[0], 1'b1};
      fault_q <= fault_q | step_err;
    end
  end

  // Dwell length and successor of the current phase.
  always_comb begin
    len = LEN_R;
    nxt = FAULT;
    case (state)
      EW_GREEN:  begin len = LEN_G; nxt = EW_YELLOW; end
      EW_YELLOW: begin len = LEN_Y; nxt = ALLRED_A;  end
      ALLRED_A:  begin len = LEN_R; nxt = NS_GREEN;  end
      NS_GREEN:  begin len = LEN_G; nxt = NS_YELLOW; end
      NS_YELLOW: begin len = LEN_Y; nxt = ALLRED_B;  end
      ALLRED_B:  begin len = LEN_R; nxt = EW_GREEN;  end
      default:   begin len = LEN_R; nxt = FAULT;     end
    endcase
  end

  // Phase FSM: fault (or a corrupt encoding) overrides any tick-driven advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ALLRED_B;
      dwell <= 4'd0;
    end else if (fault_q || step_err || state == ILLEGAL6 || state == FAULT) begin
      state <= FAULT;
      dwell <= 4'd0;
    end else if (tick) begin
      if (dwell == len - 4'd1) begin
        state <= nxt;
        dwell <= 4'd0;
      end else begin
        dwell <= dwell + 4'd1;
      end
    end
  end

`ifdef EW_FAULT_FLASH_EN
  logic [2:0] flash_div;
  logic       flash;

  // Flash divider restarts on FAULT entry so yellow always begins lit for 8 clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_div <= 3'd0;
      flash     <= 1'b0;
    end else if (state != FAULT) begin
      flash_div <= 3'd0;
      flash     <= 1'b1;
    end else begin
      flash_div <= flash_div + 3'd1;
      if (flash_div == 3'd7) flash <= ~flash;
    end
  end
`endif

  // Moore lamp decode; every non-running phase shows red both ways.
  always_comb begin
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    case (state)
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
`ifdef EW_FAULT_FLASH_EN
      FAULT: begin
        ew_red    = 1'b0;
        ns_red    = 1'b0;
        ew_yellow = flash;
        ns_yellow = flash;
      end
`endif
      default: begin
        ew_red = 1'b1;
        ns_red = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ew_light_sequencer.sv
// tb/tb_ew_light_sequencer.sv - directed self-checking bench for ew_light_sequencer
module tb_ew_light_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count = 4'd0;
  logic       ew_red, ew_yellow, ew_green, ns_red, ns_yellow, ns_green;
  logic [2:0] phase;
  logic       tick, fault;
  logic [5:0] lamps;
  logic [3:0] cval;

  int passed = 0;
  int total  = 0;

  // Expected phase after k ticks with defaults 6/2/1.
  int exp_tab [0:24] = '{5, 0,0,0,0,0,0, 1,1, 2, 3,3,3,3,3,3, 4,4, 5, 0,0,0,0,0,0};
  // Lamps {ew_r,ew_y,ew_g,ns_r,ns_y,ns_g} per phase (steady fault at index 7).
  logic [5:0] lamp_tab [0:7] = '{6'b001100, 6'b010100, 6'b100100, 6'b100001,
                                 6'b100010, 6'b100100, 6'b000000, 6'b100100};

  assign lamps = {ew_red, ew_yellow, ew_green, ns_red, ns_yellow, ns_green};

  ew_light_sequencer #(.GREEN_TICKS(6), .YELLOW_TICKS(2), .ALLRED_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .count(count),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .phase(phase), .tick(tick), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    cval  = v;
    count = v;
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    drive(cval + 4'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    count = 4'd0;
    cval  = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    count = 4'd0;
    cval  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (phase !== 3'd5) $display("FAIL reset_phase got %0d want 5", phase); else passed++;
    total++;
    if (lamps !== 6'b100100) $display("FAIL reset_lamps got %b want 100100", lamps); else passed++;
    total++;
    if (tick !== 1'b0 || fault !== 1'b0) $display("FAIL reset_flags got tick=%b fault=%b want 0 0", tick, fault);
    else passed++;
  endtask

  // Assumes do_reset just returned; walks to the first wrap and the EW_GREEN that follows.
  task automatic check_first_green(input string tag);
    repeat (15) adv();
    total++;
    if (tick !== 1'b0 || phase !== 3'd5) $display("FAIL %s_pre got tick=%b phase=%0d want 0 5", tag, tick, phase);
    else passed++;
    adv();
    total++;
    if (tick !== 1'b1 || phase !== 3'd5) $display("FAIL %s_tick got tick=%b phase=%0d want 1 5", tag, tick, phase);
    else passed++;
    adv();
    total++;
    if (phase !== 3'd0 || lamps !== 6'b001100 || tick !== 1'b0)
      $display("FAIL %s_green got phase=%0d lamps=%b tick=%b want 0 001100 0", tag, phase, lamps, tick);
    else passed++;
  endtask

  task automatic test_first_tick();
    do_reset();
    check_first_green("first");
  endtask

  task automatic test_sequence();
    int nt;
    nt = 0;
    do_reset();
    for (int i = 0; i < 24 * 16 + 1; i++) begin
      adv();
      total++;
      if (phase !== 3'(exp_tab[nt]) || lamps !== lamp_tab[exp_tab[nt]])
        $display("FAIL seq_phase cyc=%0d got phase=%0d lamps=%b want %0d %b", i, phase, lamps, exp_tab[nt], lamp_tab[exp_tab[nt]]);
      else passed++;
      total++;
      if (tick !== (cval == 4'd0)) $display("FAIL seq_tick cyc=%0d got %b want %b", i, tick, (cval == 4'd0));
      else passed++;
      if (cval == 4'd0 && nt < 24) nt++;
    end
    total++;
    if (fault !== 1'b0) $display("FAIL seq_nofault got %b want 0", fault); else passed++;
  endtask

  task automatic check_fault_hold(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      total++;
`ifdef EW_FAULT_FLASH_EN
      if (phase !== 3'd7 || fault !== 1'b1 ||
          lamps !== ((((i / 8) % 2) == 0) ? 6'b010010 : 6'b000000))
        $display("FAIL %s_flash i=%0d got phase=%0d fault=%b lamps=%b", tag, i, phase, fault, lamps);
      else passed++;
`else
      if (phase !== 3'd7 || fault !== 1'b1 || lamps !== 6'b100100)
        $display("FAIL %s_hold i=%0d got phase=%0d fault=%b lamps=%b want 7 1 100100", tag, i, phase, fault, lamps);
      else passed++;
`endif
      adv();
    end
  endtask

  task automatic test_fault_skip();
    do_reset();
    repeat (16 * 10 + 7) adv();
    total++;
    if (phase !== 3'd3 || cval !== 4'd7) $display("FAIL skip_pre got phase=%0d cnt=%0d want 3 7", phase, cval);
    else passed++;
    drive(4'd9);
    total++;
    if (fault !== 1'b0 || phase !== 3'd3) $display("FAIL skip_latency got fault=%b phase=%0d want 0 3", fault, phase);
    else passed++;
    adv();
    check_fault_hold("skip", 40);
  endtask

  task automatic test_fault_on_wrap();
    do_reset();
    repeat (16 * 9 + 1) adv();
    total++;
    if (phase !== 3'd2) $display("FAIL wrap_pre got phase=%0d want 2", phase); else passed++;
    repeat (13) adv();
    drive(4'd0);
    total++;
    if (tick !== 1'b0) $display("FAIL wrap_tick got %b want 0", tick); else passed++;
    adv();
    total++;
    if (phase !== 3'd7 || fault !== 1'b1) $display("FAIL wrap_fault got phase=%0d fault=%b want 7 1", phase, fault);
    else passed++;
    check_fault_hold("wrap", 20);
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (16 * 7 + 1 + 5) adv();
    total++;
    if (phase !== 3'd1 || lamps !== 6'b010100) $display("FAIL ares_pre got phase=%0d lamps=%b want 1 010100", phase, lamps);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (phase !== 3'd5 || lamps !== 6'b100100 || fault !== 1'b0 || tick !== 1'b0)
      $display("FAIL ares_now got phase=%0d lamps=%b fault=%b tick=%b want 5 100100 0 0", phase, lamps, fault, tick);
    else passed++;
    do_reset();
    check_first_green("ares");
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_sequence();
    test_fault_skip();
    test_fault_on_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
